// File: rtl/lt_controller_pkg.sv
// Shared definitions for the latency-tester controller: box positions, counter width, FSM states.
package lt_controller_pkg;

  localparam int unsigned LT_CNT_W = 24;

  localparam logic [1:0] LT_POS_TOPLEFT     = 2'd0;
  localparam logic [1:0] LT_POS_CENTER      = 2'd1;
  localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd2;
  localparam logic [1:0] LT_POS_FULL        = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_DARK  = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_COOLDOWN   = 3'd4
  } lt_state_e;

endpackage

// File: rtl/lt_controller_sensor_filter.sv
// Photodiode path: 2-flop synchronizer followed by a run-length debounce filter.
module lt_sensor_filter #(
  parameter int unsigned DEB_LEN = 8
) (
  input  logic clk27,
  input  logic reset,
  input  logic sensor_in,
  output logic sens_f
);

  localparam int unsigned     RUN_W    = $clog2(DEB_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  logic             sync1_q, sync2_q;
  logic             sens_f_q, sens_f_d;
  logic [RUN_W-1:0] run_q, run_d;

  // The DEB_LEN-th consecutive contrary sample flips the level; any agreeing sample restarts the run.
  always_comb begin
    sens_f_d = sens_f_q;
    run_d    = '0;
    if (sync2_q != sens_f_q) begin
      if (run_q == RUN_LAST) sens_f_d = sync2_q;
      else                   run_d    = run_q + RUN_ONE;
    end
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sens_f_q <= 1'b0;
      run_q    <= '0;
    end else begin
      sync1_q  <= sensor_in;
      sync2_q  <= sync1_q;
      sens_f_q <= sens_f_d;
      run_q    <= run_d;
    end
  end

  assign sens_f = sens_f_q;

endmodule

// File: rtl/lt_controller.sv
// Latency-tester measurement controller: arms the box on a frame start and times the sensor response.
module lt_controller
  import lt_controller_pkg::*;
#(
  parameter int unsigned      CNT_W       = LT_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 24'd13_500_000,
  parameter int unsigned      DEB_LEN     = 8
) (
  input  logic             clk27,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode_in,
  input  logic             vsync_in,
  input  logic             sensor_in,
  output logic             lt_active,
  output logic [1:0]       lt_mode,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_cnt,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lt_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             res_valid_q, res_valid_d;
  logic             timeout_q, timeout_d;
  logic             cool_dark_q, cool_dark_d;
  logic             vs_q, vs_prev_q;
  logic             vs_fall;
  logic             sens_f;

  lt_sensor_filter #(.DEB_LEN(DEB_LEN)) u_sensor_filter (
    .clk27     (clk27),
    .reset     (reset),
    .sensor_in (sensor_in),
    .sens_f    (sens_f)
  );

  assign vs_fall = vs_prev_q & ~vs_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_cnt_d   = res_cnt_q;
    mode_d      = mode_q;
    res_valid_d = 1'b0;
    timeout_d   = timeout_q;
    cool_dark_d = cool_dark_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_in;
          state_d = ST_WAIT_DARK;
        end
      end
      ST_WAIT_DARK: begin
        if (!sens_f) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (vs_fall) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (sens_f) begin
          res_cnt_d   = cnt_q;
          timeout_d   = 1'b0;
          res_valid_d = 1'b1;
          cool_dark_d = 1'b0;
          state_d     = ST_COOLDOWN;
        end else if (cnt_q == CNT_LAST) begin
          res_cnt_d   = '1;
          timeout_d   = 1'b1;
          res_valid_d = 1'b1;
          cool_dark_d = 1'b0;
          state_d     = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        // Only a frame start seen after the box has gone dark releases the controller.
        if (!sens_f) cool_dark_d = 1'b1;
        if (cool_dark_q && vs_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_cnt_q   <= '0;
      mode_q      <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cool_dark_q <= 1'b0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_cnt_q   <= res_cnt_d;
      mode_q      <= mode_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
      cool_dark_q <= cool_dark_d;
      vs_q        <= vsync_in;
      vs_prev_q   <= vs_q;
    end
  end

  assign lt_active    = (state_q == ST_MEASURE);
  assign busy         = (state_q != ST_IDLE);
  assign lt_mode      = mode_q;
  assign result_valid = res_valid_q;
  assign result_cnt   = res_cnt_q;
  assign timeout      = timeout_q;

endmodule
